// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: FSM state encoding and the parity convention
// that the RX parity checker also uses.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int DWIDTH_DEF  = 8;
   localparam int PSWIDTH_DEF = 6;

endpackage

// File: rtl/uart_tx_parity_gen.sv
// Combinational parity over a data word; even gives ^data, odd gives ~^data.
module uart_tx_parity_gen
   import uart_tx_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic [DWIDTH-1:0] i_data,
   input  logic              i_parity_type,
   output logic              o_parity
);

   function automatic logic calc_parity(input logic [DWIDTH-1:0] data, input logic ptype);
      logic w_red;
      w_red = ^data;
      if (ptype == PAR_ODD) begin
         calc_parity = ~w_red;
      end else begin
         calc_parity = w_red;
      end
   endfunction

   assign o_parity = calc_parity(i_data, i_parity_type);

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, DWIDTH data bits LSB first, optional
// parity, one stop bit; every bit lasts prescale clocks (0 behaves as 1).
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int DWIDTH  = DWIDTH_DEF,
   parameter int PSWIDTH = PSWIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DWIDTH-1:0]  i_p_data,
   input  logic               i_data_valid,
   input  logic               i_parity_en,
   input  logic               i_parity_type,
   input  logic [PSWIDTH-1:0] i_prescale,
   output logic               o_tx_out,
   output logic               o_busy
);

   localparam int              BW       = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
   localparam logic [BW-1:0]   LAST_BIT = BW'(DWIDTH - 1);

   tx_state_e            r_state;
   tx_state_e            w_state_nxt;
   logic [PSWIDTH-1:0]   r_ps_cnt, w_ps_nxt, r_ps_lim;
   logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
   logic [DWIDTH-1:0]    r_data;
   logic                 r_par_en, r_par_bit, r_tx_out, r_busy;
   logic                 w_par_bit, w_accept, w_last_tick, w_tx_nxt;

   uart_tx_parity_gen #(.DWIDTH(DWIDTH)) u_parity_gen (
      .i_data        (i_p_data),
      .i_parity_type (i_parity_type),
      .o_parity      (w_par_bit)
   );

   assign w_last_tick = (r_ps_cnt == r_ps_lim);

   // Next-state, counter and next-output-bit logic.
   always_comb begin
      w_state_nxt = r_state;
      w_ps_nxt    = r_ps_cnt + PSWIDTH'(1);
      w_bit_nxt   = r_bit_cnt;
      w_accept    = 1'b0;
      w_tx_nxt    = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_ps_nxt  = '0;
            w_bit_nxt = '0;
            if (i_data_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_START;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_START: begin
            if (w_last_tick) begin
               w_state_nxt = ST_DATA;
               w_ps_nxt    = '0;
            end else begin
               w_state_nxt = ST_START;
            end
         end
         ST_DATA: begin
            if (w_last_tick) begin
               w_ps_nxt = '0;
               if (r_bit_cnt == LAST_BIT) begin
                  w_bit_nxt   = '0;
                  w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
               end else begin
                  w_bit_nxt   = r_bit_cnt + BW'(1);
               end
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (w_last_tick) begin
               w_state_nxt = ST_STOP;
               w_ps_nxt    = '0;
            end else begin
               w_state_nxt = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (w_last_tick) begin
               w_state_nxt = ST_IDLE;
               w_ps_nxt    = '0;
            end else begin
               w_state_nxt = ST_STOP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_ps_nxt    = '0;
            w_bit_nxt   = '0;
         end
      endcase

      // Output regs track the next state so the line level lines up with r_state.
      case (w_state_nxt)
         ST_START:  w_tx_nxt = 1'b0;
         ST_DATA:   w_tx_nxt = r_data[w_bit_nxt];
         ST_PARITY: w_tx_nxt = r_par_bit;
         default:   w_tx_nxt = 1'b1;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_ps_cnt  <= '0;
         r_bit_cnt <= '0;
         r_tx_out  <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ps_cnt  <= w_ps_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_tx_out  <= w_tx_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
      end
   end

   // Shadow copy of the request, taken only at acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data    <= '0;
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
         r_ps_lim  <= '0;
      end else if (w_accept) begin
         r_data    <= i_p_data;
         r_par_en  <= i_parity_en;
         r_par_bit <= w_par_bit;
         r_ps_lim  <= (i_prescale == '0) ? '0 : (i_prescale - PSWIDTH'(1));
      end else begin
         r_data    <= r_data;
         r_par_en  <= r_par_en;
         r_par_bit <= r_par_bit;
         r_ps_lim  <= r_ps_lim;
      end
   end

   assign o_tx_out = r_tx_out;
   assign o_busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of frames against a per-cycle
// expected-waveform queue, plus mid-frame disturbance and reset sequences.
module tb_uart_tx;
   import uart_tx_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid, parity_en, parity_type;
   logic [5:0] prescale;
   logic       tx_out, busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] data;
      logic       pen;
      logic       ptype;
      logic [5:0] ps;
      logic       exp_par;
      int         exp_len;
   } vec_t;

   vec_t       vecs[9];
   logic [1:0] exp_q[$];

   uart_tx #(.DWIDTH(8), .PSWIDTH(6)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_p_data      (p_data),
      .i_data_valid  (data_valid),
      .i_parity_en   (parity_en),
      .i_parity_type (parity_type),
      .i_prescale    (prescale),
      .o_tx_out      (tx_out),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: {tx,busy} got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected line waveform for one frame plus the idle cycle after it.
   task automatic push_frame(input logic [7:0] d, input logic pen, input logic par, input logic [5:0] ps);
      int p;
      p = (ps == 6'd0) ? 1 : int'(ps);
      for (int k = 0; k < p; k++) exp_q.push_back(2'b01);
      for (int b = 0; b < 8; b++)
         for (int k = 0; k < p; k++) exp_q.push_back({d[b], 1'b1});
      if (pen)
         for (int k = 0; k < p; k++) exp_q.push_back({par, 1'b1});
      for (int k = 0; k < p; k++) exp_q.push_back(2'b11);
      exp_q.push_back(2'b10);
   endtask

   // Compare at the current falling edge, then step; bounded by the queue.
   task automatic drain(input string name, output int busy_cnt);
      logic [1:0] e;
      busy_cnt = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (busy === 1'b1) busy_cnt++;
         check2(name, {tx_out, busy}, e);
         @(negedge clk);
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int bc;
      @(negedge clk);
      p_data      = v.data;
      parity_en   = v.pen;
      parity_type = v.ptype;
      prescale    = v.ps;
      data_valid  = 1'b1;
      push_frame(v.data, v.pen, v.exp_par, v.ps);
      @(negedge clk);
      data_valid  = 1'b0;
      drain(name, bc);
      check_int({name, "_busy_len"}, bc, v.exp_len);
   endtask

   initial begin
      int         bc;
      logic [1:0] e;

      vecs[0] = '{8'hA5, 1'b1, PAR_EVEN, 6'd1,  1'b0, 11};
      vecs[1] = '{8'h00, 1'b1, PAR_ODD,  6'd1,  1'b1, 11};
      vecs[2] = '{8'h00, 1'b1, PAR_EVEN, 6'd1,  1'b0, 11};
      vecs[3] = '{8'hFF, 1'b0, PAR_EVEN, 6'd4,  1'b0, 40};
      vecs[4] = '{8'hA5, 1'b1, PAR_EVEN, 6'd0,  1'b0, 11};
      vecs[5] = '{8'h3C, 1'b0, PAR_EVEN, 6'd0,  1'b0, 10};
      vecs[6] = '{8'h81, 1'b1, PAR_ODD,  6'd3,  1'b1, 33};
      vecs[7] = '{8'h7F, 1'b1, PAR_EVEN, 6'd2,  1'b1, 22};
      vecs[8] = '{8'h6E, 1'b0, PAR_ODD,  6'd63, 1'b0, 630};

      rst = 1'b0; data_valid = 1'b0; p_data = 8'h00;
      parity_en = 1'b0; parity_type = PAR_EVEN; prescale = 6'd1;
      repeat (3) @(negedge clk);
      check2("reset_state", {tx_out, busy}, 2'b10);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check2("idle_after_reset", {tx_out, busy}, 2'b10);

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Mid-frame re-pulse and input churn; then valid held for a back-to-back frame.
      @(negedge clk);
      p_data = 8'h5A; parity_en = 1'b1; parity_type = PAR_EVEN; prescale = 6'd2;
      data_valid = 1'b1;
      push_frame(8'h5A, 1'b1, 1'b0, 6'd2);
      push_frame(8'hC3, 1'b1, 1'b1, 6'd1);
      @(negedge clk);
      data_valid = 1'b0;
      fork
         drain("midframe", bc);
         begin
            repeat (5) @(negedge clk);
            data_valid = 1'b1; p_data = 8'h3C; parity_type = PAR_ODD;
            @(negedge clk);
            data_valid = 1'b0;
            repeat (4) @(negedge clk);
            p_data = 8'hFF; parity_type = PAR_EVEN; parity_en = 1'b0; prescale = 6'd7;
            repeat (5) @(negedge clk);
            p_data = 8'hC3; parity_en = 1'b1; parity_type = PAR_ODD; prescale = 6'd1;
            data_valid = 1'b1;
            repeat (10) @(negedge clk);
            data_valid = 1'b0;
         end
      join
      check_int("midframe_busy_len", bc, 33);

      // Reset asserted during data bit 3, then line must stay idle.
      @(negedge clk);
      p_data = 8'hB6; parity_en = 1'b0; parity_type = PAR_EVEN; prescale = 6'd1;
      data_valid = 1'b1;
      push_frame(8'hB6, 1'b0, 1'b0, 6'd1);
      @(negedge clk);
      data_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         e = exp_q.pop_front();
         check2("pre_reset", {tx_out, busy}, e);
         if (k < 4) @(negedge clk);
      end
      exp_q.delete();
      #2 rst = 1'b0;
      #1 check2("async_reset_mid_frame", {tx_out, busy}, 2'b10);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check2("idle_after_abort", {tx_out, busy}, 2'b10);
      end
      run_vec(vecs[0], "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
